// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - boot-time byte-stream to instruction-memory word loader
// Assembles big-endian words from a valid/ready byte stream and holds the core until the image is written.
module instr_mem_loader #(
    parameter int Data_Width   = 32,
    parameter int Memory_Depth = 100,
    parameter int Addr_Width   = 7
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Start,
    input  logic [Addr_Width:0]   Word_Count,
    input  logic                  Byte_Valid,
    input  logic [7:0]            Byte_Data,
    output logic                  Byte_Ready,
    output logic                  Mem_WE,
    output logic [Addr_Width-1:0] Mem_Addr,
    output logic [Data_Width-1:0] Mem_WD,
    output logic                  CPU_Hold,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error
);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    localparam logic [Addr_Width:0] DEPTH = (Addr_Width+1)'(Memory_Depth);
    localparam logic [Addr_Width:0] ONE   = (Addr_Width+1)'(1);

    state_t                  state_q;
    logic [Addr_Width-1:0]   word_idx_q;
    logic [Addr_Width-1:0]   addr_q;
    logic [1:0]              byte_idx_q;
    logic [Data_Width-1:0]   shift_q;
    logic [Data_Width-1:0]   wd_q;
    logic [Addr_Width:0]     count_q;
    logic                    error_q;

    logic                    byte_fire;
    logic                    last_word;
    logic [Data_Width-1:0]   shift_d;

    assign byte_fire = Byte_Valid && (state_q == RECV);
    assign last_word = ({1'b0, word_idx_q} == (count_q - ONE));
    assign shift_d   = {shift_q[Data_Width-9:0], Byte_Data};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            word_idx_q <= '0;
            addr_q     <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            wd_q       <= '0;
            count_q    <= '0;
            error_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    // DONE accepts a new Start exactly as IDLE does
                    if (Start) begin
                        if (Word_Count == '0) begin
                            error_q <= 1'b0;
                            state_q <= DONE;
                        end else if (Word_Count > DEPTH) begin
                            error_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            count_q    <= Word_Count;
                            error_q    <= 1'b0;
                            word_idx_q <= '0;
                            byte_idx_q <= '0;
                            state_q    <= RECV;
                        end
                    end
                end
                RECV: begin
                    if (byte_fire) begin
                        shift_q    <= shift_d;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            // Address/data captured here so they hold steady outside WRITE
                            addr_q  <= word_idx_q;
                            wd_q    <= shift_d;
                            state_q <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (last_word) begin
                        state_q <= DONE;
                    end else begin
                        word_idx_q <= word_idx_q + 1'b1;
                        state_q    <= RECV;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Byte_Ready = (state_q == RECV);
    assign Mem_WE     = (state_q == WRITE);
    assign Mem_Addr   = addr_q;
    assign Mem_WD     = wd_q;
    assign Busy       = (state_q == RECV) || (state_q == WRITE);
    assign Done       = (state_q == DONE);
    assign CPU_Hold   = (state_q != DONE);
    assign Error      = error_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - directed self-checking bench for instr_mem_loader
// Inputs are driven and outputs sampled 1ns after the falling edge.
module tb_instr_mem_loader;

    localparam int AW = 7;
    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          RST;
    logic          Start;
    logic [AW:0]   Word_Count;
    logic          Byte_Valid;
    logic [7:0]    Byte_Data;
    logic          Byte_Ready;
    logic          Mem_WE;
    logic [AW-1:0] Mem_Addr;
    logic [DW-1:0] Mem_WD;
    logic          CPU_Hold;
    logic          Busy;
    logic          Done;
    logic          Error;

    instr_mem_loader #(.Data_Width(DW), .Memory_Depth(100), .Addr_Width(AW)) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .Word_Count(Word_Count),
        .Byte_Valid(Byte_Valid), .Byte_Data(Byte_Data), .Byte_Ready(Byte_Ready),
        .Mem_WE(Mem_WE), .Mem_Addr(Mem_Addr), .Mem_WD(Mem_WD),
        .CPU_Hold(CPU_Hold), .Busy(Busy), .Done(Done), .Error(Error)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]    img [0:11];
    logic [AW-1:0] wr_addr [$];
    logic [DW-1:0] wr_data [$];
    int            wr_cyc  [$];
    int            done_cyc = -1;
    logic          done_prev = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (Mem_WE === 1'b1) begin
            wr_addr.push_back(Mem_Addr);
            wr_data.push_back(Mem_WD);
            wr_cyc.push_back(cyc);
            check("ready_in_write", Byte_Ready, 1'b0);
        end
        if (Done === 1'b1 && done_prev !== 1'b1) done_cyc = cyc;
        done_prev = Done;
    end

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_cyc = -1;
    endtask

    task automatic do_reset();
        RST = 1'b1; Start = 1'b0; Word_Count = '0; Byte_Valid = 1'b0; Byte_Data = '0;
        step();
        step();
        RST = 1'b0;
    endtask

    task automatic start(input int wc);
        Start = 1'b1;
        Word_Count = (AW+1)'(wc);
        step();
        Start = 1'b0;
    endtask

    task automatic feed(input int off, input int n, input bit gappy, input int max_cyc);
        int  sent = 0;
        int  c = 0;
        bit  v;
        while (sent < n && c < max_cyc) begin
            v = !gappy || (c % 4 == 0) || (c % 4 == 3);
            Byte_Valid = v;
            Byte_Data  = v ? img[off + sent] : 8'hFF;
            if (v && Byte_Ready) sent++;
            step();
            c++;
        end
        Byte_Valid = 1'b0;
        Byte_Data  = '0;
        check("feed_bytes", sent, n);
    endtask

    task automatic wait_done(input int max_cyc);
        int c = 0;
        while (Done !== 1'b1 && c < max_cyc) begin
            step();
            c++;
        end
        check("done_reached", Done, 1'b1);
    endtask

    task automatic chk_write(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (i < wr_addr.size()) begin
            check("wr_addr", wr_addr[i], a);
            check("wr_data", wr_data[i], d);
        end else begin
            check("wr_missing", wr_addr.size(), i + 1);
        end
    endtask

    task automatic chk_reset_outputs();
        check("rst_ready", Byte_Ready, 1'b0);
        check("rst_we",    Mem_WE, 1'b0);
        check("rst_addr",  Mem_Addr, '0);
        check("rst_wd",    Mem_WD, '0);
        check("rst_busy",  Busy, 1'b0);
        check("rst_done",  Done, 1'b0);
        check("rst_hold",  CPU_Hold, 1'b1);
        check("rst_error", Error, 1'b0);
    endtask

    initial begin
        img[0] = 8'h20; img[1] = 8'h08; img[2]  = 8'h00; img[3]  = 8'h05;
        img[4] = 8'hAC; img[5] = 8'h08; img[6]  = 8'h00; img[7]  = 8'h00;
        img[8] = 8'h8C; img[9] = 8'h09; img[10] = 8'h00; img[11] = 8'h04;

        // two-word load, valid held high
        do_reset();
        chk_reset_outputs();
        clear_log();
        start(2);
        check("t1_busy", Busy, 1'b1);
        check("t1_hold", CPU_Hold, 1'b1);
        feed(0, 8, 1'b0, 100);
        wait_done(20);
        check("t1_nwr", wr_addr.size(), 2);
        chk_write(0, 7'd0, 32'h2008_0005);
        chk_write(1, 7'd1, 32'hAC08_0000);
        if (wr_cyc.size() >= 2) begin
            check("t1_spacing", wr_cyc[1] - wr_cyc[0], 5);
            check("t1_done_lat", done_cyc - wr_cyc[1], 1);
        end
        check("t1_hold_rel", CPU_Hold, 1'b0);
        check("t1_busy_end", Busy, 1'b0);

        // same image with gaps in Byte_Valid, restarted from DONE
        clear_log();
        start(2);
        check("t2_hold", CPU_Hold, 1'b1);
        feed(0, 8, 1'b1, 200);
        wait_done(20);
        check("t2_nwr", wr_addr.size(), 2);
        chk_write(0, 7'd0, 32'h2008_0005);
        chk_write(1, 7'd1, 32'hAC08_0000);

        // zero-word load
        do_reset();
        clear_log();
        start(0);
        check("t3_done", Done, 1'b1);
        check("t3_hold", CPU_Hold, 1'b0);
        check("t3_busy", Busy, 1'b0);
        step(); step(); step();
        check("t3_nwr", wr_addr.size(), 0);

        // out-of-range count, then a valid one-word load
        start(101);
        check("t4_error", Error, 1'b1);
        check("t4_ready", Byte_Ready, 1'b0);
        check("t4_busy", Busy, 1'b0);
        check("t4_hold", CPU_Hold, 1'b1);
        step();
        check("t4_error_sticky", Error, 1'b1);
        start(1);
        check("t4_error_clr", Error, 1'b0);
        check("t4_busy1", Busy, 1'b1);
        feed(8, 4, 1'b0, 50);
        wait_done(20);
        check("t4_nwr", wr_addr.size(), 1);
        chk_write(0, 7'd0, 32'h8C09_0004);

        // reset after six bytes of a three-word load
        do_reset();
        clear_log();
        start(3);
        feed(0, 6, 1'b0, 50);
        RST = 1'b1;
        step();
        RST = 1'b0;
        check("t5_nwr", wr_addr.size(), 1);
        chk_write(0, 7'd0, 32'h2008_0005);
        chk_reset_outputs();
        start(1);
        feed(8, 4, 1'b0, 50);
        wait_done(20);
        check("t5_nwr2", wr_addr.size(), 2);
        chk_write(1, 7'd0, 32'h8C09_0004);

        // Start during RECV is ignored; Start in DONE restarts
        do_reset();
        clear_log();
        start(2);
        feed(0, 2, 1'b0, 50);
        start(1);
        check("t6_busy", Busy, 1'b1);
        feed(2, 6, 1'b0, 50);
        wait_done(20);
        check("t6_nwr", wr_addr.size(), 2);
        chk_write(0, 7'd0, 32'h2008_0005);
        chk_write(1, 7'd1, 32'hAC08_0000);
        start(1);
        check("t6_hold", CPU_Hold, 1'b1);
        check("t6_done", Done, 1'b0);
        check("t6_busy2", Busy, 1'b1);
        feed(8, 4, 1'b0, 50);
        wait_done(20);
        check("t6_nwr2", wr_addr.size(), 3);
        chk_write(2, 7'd0, 32'h8C09_0004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
